// File: rtl/fader_pkg.sv
// fader_pkg: shared channel state encoding and gain arithmetic
// for the stereo fader (unity derivation, signed sample scaling).
package fader_pkg;

    typedef enum logic [1:0] {
        CH_OFF     = 2'b00,
        CH_RISING  = 2'b01,
        CH_ON      = 2'b10,
        CH_FALLING = 2'b11
    } ch_state_e;

    function automatic int gain_max(input int gain_bits);
        return (1 << gain_bits) - 1;
    endfunction

    // Operands arrive sign/zero-extended to 32 bits, so a 64-bit
    // product is always wide enough and the shift floors toward -inf.
    function automatic logic signed [31:0] scale(
        input logic signed [31:0] held,
        input logic        [31:0] gain,
        input int                 gain_bits
    );
        logic signed [63:0] prod;
        if (gain == 32'(gain_max(gain_bits))) return held;
        if (gain == '0) return '0;
        prod = 64'(held) * $signed({32'd0, gain});
        return 32'(prod >>> gain_bits);
    endfunction

endpackage

// File: rtl/stereo_fader_if.sv
// stereo_fader_if: player/MCU/codec side of the stereo fader.
// master drives samples, frame strobes and aural_state.
interface stereo_fader_if #(
    parameter int SAMPLE_WIDTH = 16
);
    logic [1:0]                     aural_state;
    logic                           new_frame;
    logic                           sample_valid;
    logic signed [SAMPLE_WIDTH-1:0] sample_in;
    logic signed [SAMPLE_WIDTH-1:0] left_out;
    logic signed [SAMPLE_WIDTH-1:0] right_out;
    logic                           ramping;

    modport master (
        output aural_state, new_frame, sample_valid, sample_in,
        input  left_out, right_out, ramping
    );

    modport slave (
        input  aural_state, new_frame, sample_valid, sample_in,
        output left_out, right_out, ramping
    );
endinterface

// File: rtl/fader_channel.sv
// fader_channel: one gain ramp FSM, gain register and scaled output.
// FADER_ZERO_CROSS_EN defers steps to sample zero crossings.
import fader_pkg::*;

module fader_channel #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int GAIN_BITS    = 8,
`ifdef FADER_ZERO_CROSS_EN
    parameter int ZC_TIMEOUT   = 64,
`endif
    parameter int RAMP_STEP    = 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           enable,
    input  logic                           new_frame,
    input  logic signed [SAMPLE_WIDTH-1:0] held,
    output logic signed [SAMPLE_WIDTH-1:0] sample_out,
    output logic                           ramp_next
);

    localparam logic [GAIN_BITS-1:0] GMAX =
        GAIN_BITS'(gain_max(GAIN_BITS));
    localparam logic [GAIN_BITS:0] STEP =
        (GAIN_BITS+1)'(RAMP_STEP);

    ch_state_e            state_q, state_d, dir_s;
    logic [GAIN_BITS-1:0] gain_q, gain_d;
    logic [GAIN_BITS:0]   up_sum, dn_diff;
    logic                 step_ok, step_en, ramp_dir;

    assign up_sum  = {1'b0, gain_q} + STEP;
    assign dn_diff = {1'b0, gain_q} - STEP;

    always_comb begin
        dir_s    = state_q;
        state_d  = state_q;
        gain_d   = gain_q;
        ramp_dir = 1'b0;
        step_en  = 1'b0;
        unique case (state_q)
            CH_OFF:     if (enable)  dir_s = CH_RISING;
            CH_ON:      if (!enable) dir_s = CH_FALLING;
            CH_RISING:  if (!enable) dir_s = CH_FALLING;
            CH_FALLING: if (enable)  dir_s = CH_RISING;
            default:    dir_s = CH_OFF;
        endcase
        ramp_dir = (dir_s == CH_RISING) || (dir_s == CH_FALLING);
        step_en  = new_frame && step_ok && ramp_dir;
        state_d  = dir_s;
        // Direction settles first; a step on the same edge follows it.
        if (step_en) begin
            if (dir_s == CH_RISING) begin
                gain_d = (up_sum > {1'b0, GMAX}) ?
                         GMAX : up_sum[GAIN_BITS-1:0];
                if (gain_d == GMAX) state_d = CH_ON;
            end else begin
                gain_d = dn_diff[GAIN_BITS] ?
                         '0 : dn_diff[GAIN_BITS-1:0];
                if (gain_d == '0) state_d = CH_OFF;
            end
        end
    end

    assign ramp_next = (state_d == CH_RISING) ||
                       (state_d == CH_FALLING);

`ifdef FADER_ZERO_CROSS_EN
    localparam int CW = (ZC_TIMEOUT > 1) ? $clog2(ZC_TIMEOUT) : 1;

    logic [CW-1:0] zc_cnt_q;
    logic          prev_neg_q;

    assign step_ok = (held == '0) ||
                     (held[SAMPLE_WIDTH-1] != prev_neg_q) ||
                     (zc_cnt_q == CW'(ZC_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            zc_cnt_q   <= '0;
            prev_neg_q <= 1'b0;
        end else begin
            if (new_frame) prev_neg_q <= held[SAMPLE_WIDTH-1];
            if (!ramp_dir || step_en) zc_cnt_q <= '0;
            else if (new_frame)       zc_cnt_q <= zc_cnt_q + 1'b1;
        end
    end
`else
    assign step_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= CH_OFF;
            gain_q     <= '0;
            sample_out <= '0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
            if (new_frame)
                sample_out <= SAMPLE_WIDTH'(
                    scale(32'(held), 32'(gain_q), GAIN_BITS));
        end
    end

endmodule

// File: rtl/stereo_fader.sv
// stereo_fader: click-free L/R gain ramps between player and codec.
// Define FADER_ZERO_CROSS_EN to align gain steps with zero crossings.
import fader_pkg::*;

module stereo_fader #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int GAIN_BITS    = 8,
    parameter int RAMP_STEP    = 1,
    parameter int ZC_TIMEOUT   = 64
) (
    input  logic           clk,
    input  logic           reset_n,
    stereo_fader_if.slave  bus
);

    if (RAMP_STEP < 1 || RAMP_STEP > gain_max(GAIN_BITS) ||
        ZC_TIMEOUT < 1) begin : g_bad_cfg
        $error("stereo_fader: RAMP_STEP or ZC_TIMEOUT out of range");
    end

    logic signed [SAMPLE_WIDTH-1:0] held_q;
    logic                           l_ramp, r_ramp;
    logic                           ramping_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            held_q    <= '0;
            ramping_q <= 1'b0;
        end else begin
            if (bus.sample_valid) held_q <= bus.sample_in;
            ramping_q <= l_ramp | r_ramp;
        end
    end

    assign bus.ramping = ramping_q;

    fader_channel #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .GAIN_BITS    (GAIN_BITS),
`ifdef FADER_ZERO_CROSS_EN
        .ZC_TIMEOUT   (ZC_TIMEOUT),
`endif
        .RAMP_STEP    (RAMP_STEP)
    ) u_left (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (bus.aural_state[0]),
        .new_frame  (bus.new_frame),
        .held       (held_q),
        .sample_out (bus.left_out),
        .ramp_next  (l_ramp)
    );

    fader_channel #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .GAIN_BITS    (GAIN_BITS),
`ifdef FADER_ZERO_CROSS_EN
        .ZC_TIMEOUT   (ZC_TIMEOUT),
`endif
        .RAMP_STEP    (RAMP_STEP)
    ) u_right (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (bus.aural_state[1]),
        .new_frame  (bus.new_frame),
        .held       (held_q),
        .sample_out (bus.right_out),
        .ramp_next  (r_ramp)
    );

endmodule

// File: tb/tb_stereo_fader.sv
// tb_stereo_fader: directed plan plus random traffic against a
// settle/step reference model of the fader (GAIN_BITS=8, step 51).
module tb_stereo_fader;

    localparam int SW   = 16;
    localparam int GB   = 8;
    localparam int STEP = 51;
    localparam int ZCT  = 4;
    localparam int GMAX = 255;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    stereo_fader_if #(.SAMPLE_WIDTH(SW)) bus();

    stereo_fader #(
        .SAMPLE_WIDTH (SW),
        .GAIN_BITS    (GB),
        .RAMP_STEP    (STEP),
        .ZC_TIMEOUT   (ZCT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int failures = 0;

    int m_held;
    int m_gain[2];
    int m_out[2];
    int m_cnt[2];
    bit m_busy[2];
    bit m_ramp;
    bit m_prev_neg;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic int ref_scale(input int h, input int g);
        int p, q;
        if (g == GMAX) return h;
        if (g == 0) return 0;
        p = h * g;
        q = p / 256;
        if (p < 0 && q * 256 != p) q = q - 1;
        return q;
    endfunction

    function automatic void model_reset();
        m_held = 0;
        m_ramp = 0;
        m_prev_neg = 0;
        for (int c = 0; c < 2; c++) begin
            m_gain[c] = 0;
            m_out[c]  = 0;
            m_cnt[c]  = 0;
            m_busy[c] = 0;
        end
    endfunction

    // A channel is busy from the moment its target departs from its
    // settled gain until a frame lands the gain on the target.
    function automatic void model_step(input logic [1:0] en,
                                       input logic nf,
                                       input logic sv,
                                       input int sin);
        int tgt;
        bit ok;
        for (int c = 0; c < 2; c++) begin
            tgt = en[c] ? GMAX : 0;
            if (!m_busy[c] && m_gain[c] != tgt) m_busy[c] = 1;
            if (nf) begin
                m_out[c] = ref_scale(m_held, m_gain[c]);
                ok = 1;
`ifdef FADER_ZERO_CROSS_EN
                ok = (m_held == 0) || ((m_held < 0) != m_prev_neg) ||
                     (m_cnt[c] == ZCT - 1);
`endif
                if (m_busy[c]) begin
                    if (ok) begin
                        if (tgt > m_gain[c])
                            m_gain[c] = (m_gain[c] + STEP > GMAX) ?
                                        GMAX : m_gain[c] + STEP;
                        else if (tgt < m_gain[c])
                            m_gain[c] = (m_gain[c] - STEP < 0) ?
                                        0 : m_gain[c] - STEP;
                        if (m_gain[c] == tgt) m_busy[c] = 0;
                        m_cnt[c] = 0;
                    end else begin
                        m_cnt[c]++;
                    end
                end
            end
            if (!m_busy[c]) m_cnt[c] = 0;
        end
        if (nf) m_prev_neg = (m_held < 0);
        if (sv) m_held = sin;
        m_ramp = m_busy[0] | m_busy[1];
    endfunction

    task automatic tick(input logic [1:0] en, input logic nf,
                        input logic sv, input int sin);
        bus.aural_state  = en;
        bus.new_frame    = nf;
        bus.sample_valid = sv;
        bus.sample_in    = SW'(sin);
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_step(en, nf, sv, sin);
        #1;
        chk("m_left", int'(bus.left_out), m_out[0]);
        chk("m_right", int'(bus.right_out), m_out[1]);
        chk("m_ramp", int'(bus.ramping), int'(m_ramp));
    endtask

    task automatic frame(input logic [1:0] en);
        tick(en, 1'b1, 1'b0, 0);
        tick(en, 1'b0, 1'b0, 0);
    endtask

    task automatic async_reset();
        #3;
        reset_n = 1'b0;
        #1;
        chk("rst_left", int'(bus.left_out), 0);
        chk("rst_right", int'(bus.right_out), 0);
        chk("rst_ramp", int'(bus.ramping), 0);
        model_reset();
        tick(2'b00, 1'b0, 1'b0, 0);
        reset_n = 1'b1;
    endtask

`ifndef FADER_ZERO_CROSS_EN
    task automatic default_directed();
        int e1[6] = '{0, 3264, 6528, 9792, 13056, 16384};
        int e2[6] = '{-16384, -13056, -9792, -6528, -3264, 0};
        tick(2'b11, 1'b0, 1'b1, 16'h4000);
        for (int k = 0; k < 6; k++) begin
            frame(2'b11);
            chk("up_left", int'(bus.left_out), e1[k]);
            chk("up_right", int'(bus.right_out), e1[k]);
            chk("up_ramp", int'(bus.ramping), (k < 4) ? 1 : 0);
        end
        tick(2'b10, 1'b0, 1'b1, -16384);
        for (int k = 0; k < 6; k++) begin
            frame(2'b10);
            chk("dn_left", int'(bus.left_out), e2[k]);
            chk("dn_right", int'(bus.right_out), -16384);
        end
        tick(2'b11, 1'b0, 1'b1, 16'h4000);
        frame(2'b11);
        frame(2'b11);
        chk("rev_pre", int'(bus.left_out), 3264);
        frame(2'b10);
        chk("rev_fall", int'(bus.left_out), 6528);
        frame(2'b11);
        chk("rev_g51", int'(bus.left_out), 3264);
        frame(2'b11);
        chk("rev_rise", int'(bus.left_out), 6528);
        for (int k = 0; k < 3; k++) frame(2'b11);
        chk("max_ramp", int'(bus.ramping), 0);
        tick(2'b11, 1'b0, 1'b1, 16'h1000);
        frame(2'b11);
        tick(2'b11, 1'b1, 1'b1, 16'h7FFF);
        tick(2'b11, 1'b0, 1'b0, 0);
        chk("coin_old", int'(bus.left_out), 16'h1000);
        chk("coin_old_r", int'(bus.right_out), 16'h1000);
        frame(2'b11);
        chk("coin_new", int'(bus.left_out), 16'h7FFF);
        tick(2'b00, 1'b0, 1'b0, 0);
        frame(2'b00);
    endtask
`else
    task automatic zc_directed();
        tick(2'b11, 1'b0, 1'b1, 16'h4000);
        for (int k = 0; k < 4; k++) begin
            frame(2'b11);
            chk("zc_wait", int'(bus.left_out), 0);
        end
        frame(2'b11);
        chk("zc_timeout", int'(bus.left_out), 3264);
        tick(2'b11, 1'b0, 1'b1, -16384);
        frame(2'b11);
        chk("zc_flip", int'(bus.left_out), -3264);
        frame(2'b11);
        chk("zc_stepped", int'(bus.left_out), -6528);
        frame(2'b11);
        chk("zc_held", int'(bus.left_out), -6528);
    endtask
`endif

    initial begin
        logic [1:0]        en;
        logic signed [15:0] s16;
        int                 sin;
        bus.aural_state  = 2'b00;
        bus.new_frame    = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample_in    = '0;
        model_reset();
        #12;
        chk("reset_left", int'(bus.left_out), 0);
        chk("reset_right", int'(bus.right_out), 0);
        chk("reset_ramp", int'(bus.ramping), 0);
        reset_n = 1'b1;

`ifdef FADER_ZERO_CROSS_EN
        zc_directed();
`else
        default_directed();
`endif

        async_reset();
        tick(2'b11, 1'b0, 1'b1, 16'h4000);
        frame(2'b11);
        frame(2'b11);
`ifdef FADER_ZERO_CROSS_EN
        chk("restart", int'(bus.left_out), 0);
`else
        chk("restart", int'(bus.left_out), 3264);
`endif

        en = 2'b11;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) en = 2'($urandom);
            case ($urandom_range(0, 3))
                0:       s16 = 16'sd0;
                1:       s16 = 16'($signed($urandom_range(0, 6)) - 3);
                default: s16 = 16'($urandom);
            endcase
            sin = s16;
            tick(en, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0, sin);
            if ($urandom_range(0, 999) == 0) async_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
